vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed 640x480 controller and 25 MHz divider pair.
- Derives the pixel-rate enable internally from clk, runs the horizontal/vertical counters, and decodes sync, valid and frame/line markers.
- Adds a configurable sync/valid delay line so the pixel generator can be pipelined without misaligning sync.
- Sits between the board clock and the pixel generator inside the top-level video wrapper.

Parameters:
- CLK_DIV, 4, clk cycles per pixel; must be >=1; 1 means a tick every cycle.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels; must be >=1.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines; must be >=1.
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level.
- PIPE_DLY, 0, pixel ticks of delay applied to the *_dly outputs.
- CNT_W, 10, counter width; must hold max(H_TOTAL,V_TOTAL)-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes the divider, counters and all outputs.
- pix_tick  out  1  one-clk pulse marking a pixel advance.
- h_cnt  out  CNT_W  current pixel column.
- v_cnt  out  CNT_W  current line.
- hsync  out  1  horizontal sync, aligned with h_cnt/v_cnt.
- vsync  out  1  vertical sync, aligned with h_cnt/v_cnt.
- valid  out  1  high when the current pixel is in the active area.
- line_start  out  1  one-clk pulse in the first cycle h_cnt==0.
- frame_start  out  1  one-clk pulse in the first cycle h_cnt==0 && v_cnt==0.
- hsync_dly  out  1  hsync delayed by PIPE_DLY ticks.
- vsync_dly  out  1  vsync delayed by PIPE_DLY ticks.
- valid_dly  out  1  valid delayed by PIPE_DLY ticks.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Default is 800x525.
- Reset (synchronous, takes priority over en):
  - divider = 0, h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1.
  - hsync = !HS_POL, vsync = !VS_POL, valid = 0.
  - pix_tick, line_start, frame_start = 0.
  - The delay line is flushed to inactive sync levels with valid 0.
  - This reset state is a legal blanking position, so the decode invariant below holds at reset.
- Divider: increments on clk while en is high and wraps at CLK_DIV-1. pix_tick is registered and asserts for one clk on the edge where the divider wraps. With CLK_DIV=1, pix_tick is high on every enabled cycle.
- Counters: on each tick, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt advances; v_cnt wraps from V_TOTAL-1 to 0. First tick after reset produces (0,0).
- Decode: all decoded outputs are registered and update on the same edge as the counters. Invariant every cycle:
  - valid = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else !VS_POL. vsync depends on v_cnt only.
- line_start / frame_start: asserted for exactly one clk (not a whole pixel period), in the cycle the counters take the new value.
- Delay line: PIPE_DLY-stage shift of {hsync,vsync,valid}, advancing only on ticks. With PIPE_DLY=0 the *_dly outputs equal the undelayed outputs combinationally.
- en low: counters, divider, all outputs and the delay line hold. Pulse outputs read 0 while en is low. On resume, the divider continues from its held value.
- rst mid-frame: the next edge returns everything to the reset state. The first tick after rst deasserts begins a fresh frame with frame_start.
- Illegal parameters (H_BP=0, V_BP=0, CLK_DIV=0, totals overflowing CNT_W) are rejected by an elaboration-time check.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480@60 timing constants;
  - the derived-total computation;
  - the sync decode window bounds as functions of the parameters.
- Sub-module vga_sync_delay: parametrised PIPE_DLY-deep, 3-bit-wide shift register with a tick enable and synchronous reset value input.

Test Plan:
1. Defaults, release rst, en=1:
   - pix_tick first rises 4 clks after release.
   - The same edge shows h_cnt=0, v_cnt=0, valid=1, frame_start=1 and line_start=1, each for 1 clk.
   - pix_tick then repeats every 4 clks.
2. Defaults, line timing:
   - hsync=0 for h_cnt 656..751 and 1 at 752.
   - valid=0 at h_cnt 640.
   - h_cnt 799 → 0 with v_cnt+1 and a line_start pulse.
3. Defaults, full frame:
   - vsync=0 only while v_cnt is 490..491.
   - The next frame_start follows 420000 ticks (1,680,000 clks) after the previous one.
4. Hold en low for 37 clks mid-line at h_cnt=100:
   - Counters, syncs and the divider hold; no pulses appear.
   - After en returns high, h_cnt reaches 101 after the remaining divider cycles.
5. Assert rst at v_cnt=200, h_cnt=300:
   - The next edge shows h_cnt=799, v_cnt=524, valid=0, hsync=vsync=1.
   - After release, the first tick produces frame_start.
6. Small configuration: CLK_DIV=1, H=8/1/2/1, V=4/1/1/1, HS_POL=1, PIPE_DLY=2:
   - hsync=1 at h_cnt 9..10.
   - hsync_dly, vsync_dly and valid_dly match the undelayed outputs shifted exactly 2 cycles.
   - After reset, the *_dly outputs show inactive values for the first 2 ticks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : default 640x480@60 timing and sync-window helpers
// Revision: 1.0
// ============================================================================
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int total_len(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Sync window is the half-open range [sync_start, sync_end).
  function automatic int sync_start(int active, int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(int active, int fp, int sync);
    return active + fp + sync;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// vga_sync_delay : tick-enabled shift register for the sync/valid bundle
// Revision: 1.0
// ============================================================================
module vga_sync_delay #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic bypass_unused;
      assign bypass_unused = ^{clk, rst, tick, rst_val};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= rst_val;
        end else if (tick) begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised VGA counters, sync decode and delayed syncs
// Revision: 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync_dly,
  output logic             vsync_dly,
  output logic             valid_dly
);

  localparam int H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam bit PARAMS_OK = (CLK_DIV >= 1) && (H_BP >= 1) && (V_BP >= 1) && (PIPE_DLY >= 0)
                          && (longint'(H_TOTAL) <= (longint'(1) << CNT_W))
                          && (longint'(V_TOTAL) <= (longint'(1) << CNT_W));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("vga_timing_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             pix_tick_r;
  logic             line_start_r;
  logic             frame_start_r;
  logic [2:0]       dly_out;

  assign tick = en && (div == DIV_LAST);

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
  end

  // Decode is taken from the next counter values so it lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div           <= '0;
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      hsync         <= !HS_POL;
      vsync         <= !VS_POL;
      valid         <= 1'b0;
      pix_tick_r    <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      pix_tick_r    <= tick;
      line_start_r  <= tick && (h_nxt == '0);
      frame_start_r <= tick && (h_nxt == '0) && (v_nxt == '0);
      if (en) begin
        div   <= (div == DIV_LAST) ? '0 : div + 1'b1;
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        valid <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
        hsync <= ((h_nxt >= HS_START_C) && (h_nxt < HS_END_C)) ? HS_POL : !HS_POL;
        vsync <= ((v_nxt >= VS_START_C) && (v_nxt < VS_END_C)) ? VS_POL : !VS_POL;
      end
    end
  end

  // Pulses are masked so they read low for the whole time en is low.
  assign pix_tick    = pix_tick_r & en;
  assign line_start  = line_start_r & en;
  assign frame_start = frame_start_r & en;

  vga_sync_delay #(
    .DEPTH (PIPE_DLY),
    .WIDTH (3)
  ) u_sync_delay (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .rst_val ({!HS_POL, !VS_POL, 1'b0}),
    .din     ({hsync, vsync, valid}),
    .dout    (dly_out)
  );

  assign {hsync_dly, vsync_dly, valid_dly} = dly_out;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : vector table, corner sequences and randomised model check
// Revision: 1.0
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int div; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
    bit hp; bit vp; int dly;
  } cfg_t;

  typedef struct {
    int h; int v;
    bit valid; bit hs; bit vs; bit tick; bit ls; bit fs; bit hsd; bit vsd; bit vald;
  } exp_t;

  typedef struct {
    bit rst; bit en; int cyc; int h; int v;
    bit valid; bit hs; bit vs; bit tick; bit ls; bit fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // default 640x480 instance
  logic       d_tick, d_hs, d_vs, d_valid, d_ls, d_fs, d_hsd, d_vsd, d_vald;
  logic [9:0] d_h, d_v;
  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en), .pix_tick(d_tick), .h_cnt(d_h), .v_cnt(d_v),
    .hsync(d_hs), .vsync(d_vs), .valid(d_valid), .line_start(d_ls), .frame_start(d_fs),
    .hsync_dly(d_hsd), .vsync_dly(d_vsd), .valid_dly(d_vald));

  // tiny instance: CLK_DIV=1, positive hsync, two-tick delay
  logic       s_tick, s_hs, s_vs, s_valid, s_ls, s_fs, s_hsd, s_vsd, s_vald;
  logic [3:0] s_h, s_v;
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(2), .CNT_W(4)
  ) u_small (
    .clk(clk), .rst(rst), .en(en), .pix_tick(s_tick), .h_cnt(s_h), .v_cnt(s_v),
    .hsync(s_hs), .vsync(s_vs), .valid(s_valid), .line_start(s_ls), .frame_start(s_fs),
    .hsync_dly(s_hsd), .vsync_dly(s_vsd), .valid_dly(s_vald));

  // mid instance: CLK_DIV=2, positive vsync, one-tick delay
  logic       m_tick, m_hs, m_vs, m_valid, m_ls, m_fs, m_hsd, m_vsd, m_vald;
  logic [4:0] m_h, m_v;
  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(1), .CNT_W(5)
  ) u_mid (
    .clk(clk), .rst(rst), .en(en), .pix_tick(m_tick), .h_cnt(m_h), .v_cnt(m_v),
    .hsync(m_hs), .vsync(m_vs), .valid(m_valid), .line_start(m_ls), .frame_start(m_fs),
    .hsync_dly(m_hsd), .vsync_dly(m_vsd), .valid_dly(m_vald));

  cfg_t CD, CS, CM;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(int h, int v, bit valid, bit hs, bit vs, bit tick,
                                     bit ls, bit fs, bit hsd, bit vsd, bit vald);
    return {3'b000, 10'(h), 10'(v), valid, hs, vs, tick, ls, fs, hsd, vsd, vald};
  endfunction

  function automatic logic [31:0] pk_x(exp_t x);
    return pk(x.h, x.v, x.valid, x.hs, x.vs, x.tick, x.ls, x.fs, x.hsd, x.vsd, x.vald);
  endfunction

  function automatic logic [31:0] act_d();
    return pk(int'(d_h), int'(d_v), d_valid, d_hs, d_vs, d_tick, d_ls, d_fs, d_hsd, d_vsd, d_vald);
  endfunction
  function automatic logic [31:0] act_s();
    return pk(int'(s_h), int'(s_v), s_valid, s_hs, s_vs, s_tick, s_ls, s_fs, s_hsd, s_vsd, s_vald);
  endfunction
  function automatic logic [31:0] act_m();
    return pk(int'(m_h), int'(m_v), m_valid, m_hs, m_vs, m_tick, m_ls, m_fs, m_hsd, m_vsd, m_vald);
  endfunction

  // Raster position after n pixel ticks since reset; n=0 is the last pixel of a frame.
  function automatic void place(cfg_t c, longint n, output int h, output int v);
    longint ht, tot, p;
    ht  = c.ha + c.hf + c.hs + c.hb;
    tot = ht * (c.va + c.vf + c.vs + c.vb);
    p   = (n + tot - 1) % tot;
    h   = int'(p % ht);
    v   = int'(p / ht);
  endfunction

  function automatic void decode(cfg_t c, int h, int v, output bit valid, output bit hs, output bit vs);
    valid = (h < c.ha) && (v < c.va);
    hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
    vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
  endfunction

  // e = enabled clock edges since reset, ee = the latest edge was enabled.
  function automatic exp_t model(cfg_t c, longint e, bit ee);
    exp_t x;
    longint n, nd;
    int hd, vd;
    n = e / c.div;
    place(c, n, x.h, x.v);
    decode(c, x.h, x.v, x.valid, x.hs, x.vs);
    x.tick = ee && (e % c.div == 0);
    x.ls   = x.tick && (x.h == 0);
    x.fs   = x.ls && (x.v == 0);
    nd = (n - c.dly < 0) ? 0 : n - c.dly;
    place(c, nd, hd, vd);
    decode(c, hd, vd, x.vald, x.hsd, x.vsd);
    return x;
  endfunction

  function automatic bit fs_of(int which);
    return (which == 0) ? d_fs : (which == 1) ? s_fs : m_fs;
  endfunction

  task automatic frame_period(string name, int which, int want_clks);
    int cnt;
    bit seen;
    rst = 1'b1; en = 1'b1; step(1); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      step(1);
      if (fs_of(which)) seen = 1'b1;
    end
    check({name, "_first"}, 32'(seen), 32'd1);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      step(1);
      cnt++;
      if (fs_of(which)) seen = 1'b1;
    end
    check(name, 32'(cnt), 32'(want_clks));
  endtask

  vec_t tbl[$];
  logic [2:0] hist[$];

  initial begin
    exp_t x;
    longint e;
    bit ee;
    logic [2:0] want;

    CD = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};
    CS = '{1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0, 2};
    CM = '{2, 16, 2, 3, 2, 6, 2, 2, 2, 1'b0, 1'b1, 1};

    //               rst   en    cyc   h    v    valid hs    vs    tick  ls    fs
    tbl.push_back('{1'b1, 1'b1, 2,    799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3,    799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1,    0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3,    1,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 396,  100, 0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,    100, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 37,   100, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2,    100, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,    101, 0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2156, 640, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 64,   656, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 380,  751, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4,    752, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 188,  799, 0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4,    0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1200, 300, 1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1,    799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3,    799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,    0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      en  = tbl[i].en;
      step(tbl[i].cyc);
      check($sformatf("vec%0d", i), act_d(),
            pk(tbl[i].h, tbl[i].v, tbl[i].valid, tbl[i].hs, tbl[i].vs, tbl[i].tick,
               tbl[i].ls, tbl[i].fs, tbl[i].hs, tbl[i].vs, tbl[i].valid));
    end

    // Two-tick delay line on the CLK_DIV=1 instance.
    rst = 1'b1; en = 1'b1; step(1); rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      x = model(CS, longint'(i + 1), 1'b1);
      check("small_seq", act_s(), pk_x(x));
      want = (i < 2) ? 3'b010 : hist[i-2];
      check("small_dly2", {29'b0, s_hsd, s_vsd, s_vald}, {29'b0, want});
      hist.push_back({x.hs, x.vs, x.valid});
    end

    frame_period("small_frame", 1, CS.div * (CS.ha+CS.hf+CS.hs+CS.hb) * (CS.va+CS.vf+CS.vs+CS.vb));
    frame_period("mid_frame", 2, CM.div * (CM.ha+CM.hf+CM.hs+CM.hb) * (CM.va+CM.vf+CM.vs+CM.vb));

    // Random en/rst against the reference model for all three instances.
    rst = 1'b1; en = 1'b1; step(1);
    e = 0; ee = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(499) == 0);
      en  = ($urandom_range(9) != 0);
      step(1);
      if (rst) begin e = 0; ee = 1'b0; end
      else if (en) begin e++; ee = 1'b1; end
      else ee = 1'b0;
      check("rand_def", act_d(), pk_x(model(CD, e, ee)));
      check("rand_small", act_s(), pk_x(model(CS, e, ee)));
      check("rand_mid", act_m(), pk_x(model(CM, e, ee)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
